regfile_op_sequencer: RTL



---
 rtl/regfile_seq_pkg.sv | 25 ++
 rtl/regfile_op_sequencer_if.sv | 38 +++
 rtl/regfile_seq_alu.sv | 49 ++++
 rtl/regfile_op_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file operation sequencer: opcodes, FSM states and default
// datapath/address widths.
package regfile_seq_pkg;

  localparam int unsigned RF_DW = 8;
  localparam int unsigned RF_AW = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    EX   = 3'd2,
    WB   = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_op_sequencer_if.sv
// Request handshake plus register-file port set. The sequencer uses the master modport; the
// decode stage and the register file sit on the slave side.
interface regfile_op_sequencer_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
);

  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [AW-1:0] req_src1;
  logic [AW-1:0] req_src2;
  logic [AW-1:0] req_dst;

  logic          rf_rd;
  logic [AW-1:0] rf_addr1;
  logic [AW-1:0] rf_addr2;
  logic [DW-1:0] rf_data_out1;
  logic [DW-1:0] rf_data_out2;
  logic          rf_wr;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_data_in;

  modport master (
    input  req_valid, req_op, req_src1, req_src2, req_dst,
    output req_ready,
    output rf_rd, rf_addr1, rf_addr2, rf_wr, rf_wr_addr, rf_data_in,
    input  rf_data_out1, rf_data_out2
  );

  modport slave (
    output req_valid, req_op, req_src1, req_src2, req_dst,
    input  req_ready,
    input  rf_rd, rf_addr1, rf_addr2, rf_wr, rf_wr_addr, rf_data_in,
    output rf_data_out1, rf_data_out2
  );

endinterface

// File: rtl/regfile_seq_alu.sv
// Combinational ALU for the sequencer. wr_en is low only for CMP, which updates flags without
// writing a register.
module regfile_seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int unsigned DW = RF_DW
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y,
  output logic          carry,
  output logic          wr_en
);

  logic [DW:0] ext;

  always_comb begin
    ext   = '0;
    y     = '0;
    carry = 1'b0;
    wr_en = 1'b1;
    case (op)
      OP_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        y     = ext[DW-1:0];
        carry = ext[DW];
      end
      // The extra MSB of a zero-extended subtraction is the borrow (a < b).
      OP_SUB, OP_CMP: begin
        ext   = {1'b0, a} - {1'b0, b};
        y     = ext[DW-1:0];
        carry = ext[DW];
        wr_en = (op != OP_CMP);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_MOV: y = a;
      OP_INC: begin
        ext   = {1'b0, a} + (DW + 1)'(1);
        y     = ext[DW-1:0];
        carry = ext[DW];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Sequences one register-register operation at a time: read two operands, run the ALU, write
// the result back with a setup and hold cycle around rf_wr, then pulse done.
module regfile_op_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int unsigned DW        = RF_DW,
  parameter int unsigned AW        = RF_AW,
  parameter int unsigned READ_WAIT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_op_sequencer_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic [DW-1:0]          result,
  output logic                   zero,
  output logic                   carry
);

  if (READ_WAIT < 1 || READ_WAIT > 4) begin : gen_bad_read_wait
    $error("READ_WAIT must be in 1..4");
  end

  localparam logic [2:0] RdLast = 3'(READ_WAIT - 1);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] dst_q, dst_d;
  logic          wb_q, wb_d;

  logic          req_ready_q, req_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] result_q, result_d;
  logic          zero_q, zero_d;
  logic          carry_q, carry_d;
  logic          rf_rd_q, rf_rd_d;
  logic [AW-1:0] rf_addr1_q, rf_addr1_d;
  logic [AW-1:0] rf_addr2_q, rf_addr2_d;
  logic          rf_wr_q, rf_wr_d;
  logic [AW-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic [DW-1:0] rf_data_in_q, rf_data_in_d;

  logic [DW-1:0] alu_y;
  logic          alu_carry;
  logic          alu_wr_en;
  logic          accept;

  // Operands feed the ALU straight from the file and are captured as a registered result on
  // the last RD edge, so rf_data_in is already stable during EX, one cycle ahead of rf_wr.
  regfile_seq_alu #(
    .DW(DW)
  ) u_alu (
    .op   (op_q),
    .a    (bus.rf_data_out1),
    .b    (bus.rf_data_out2),
    .y    (alu_y),
    .carry(alu_carry),
    .wr_en(alu_wr_en)
  );

  assign accept = bus.req_valid && req_ready_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    dst_d        = dst_q;
    wb_d         = wb_q;
    result_d     = result_q;
    zero_d       = zero_q;
    carry_d      = carry_q;
    rf_addr1_d   = rf_addr1_q;
    rf_addr2_d   = rf_addr2_q;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_data_in_d = rf_data_in_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d       = bus.req_op;
          dst_d      = bus.req_dst;
          rf_addr1_d = bus.req_src1;
          rf_addr2_d = bus.req_src2;
          cnt_d      = '0;
          state_d    = RD;
        end
      end
      RD: begin
        if (cnt_q == RdLast) begin
          result_d     = alu_y;
          zero_d       = (alu_y == '0);
          carry_d      = alu_carry;
          wb_d         = alu_wr_en;
          rf_wr_addr_d = dst_q;
          rf_data_in_d = alu_y;
          state_d      = EX;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      EX:      state_d = wb_q ? WB : DONE;
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Control outputs are registered copies of the next state.
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rf_rd_d     = (state_d == RD);
    rf_wr_d     = (state_d == WB);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      dst_q        <= '0;
      wb_q         <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
      rf_rd_q      <= 1'b0;
      rf_addr1_q   <= '0;
      rf_addr2_q   <= '0;
      rf_wr_q      <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_data_in_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      dst_q        <= dst_d;
      wb_q         <= wb_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      carry_q      <= carry_d;
      rf_rd_q      <= rf_rd_d;
      rf_addr1_q   <= rf_addr1_d;
      rf_addr2_q   <= rf_addr2_d;
      rf_wr_q      <= rf_wr_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_data_in_q <= rf_data_in_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_addr1   = rf_addr1_q;
  assign bus.rf_addr2   = rf_addr2_q;
  assign bus.rf_wr      = rf_wr_q;
  assign bus.rf_wr_addr = rf_wr_addr_q;
  assign bus.rf_data_in = rf_data_in_q;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign carry  = carry_q;

endmodule
